// File: rtl/rs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs_pkg                                                       |
// | Description : Shared types and constant functions for the Reed-Solomon     |
// |               encoder: field polynomials, GF multiply, generator poly.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rs_pkg;

  localparam int C_MAX_BW = 8;
  localparam int C_MAX_R  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Primitive polynomial (including the x^bw term) for each supported width.
  function automatic int prim_poly(input int bw);
    case (bw)
      3:       return 'h00B;
      4:       return 'h013;
      5:       return 'h025;
      6:       return 'h043;
      7:       return 'h089;
      default: return 'h11D;
    endcase
  endfunction

  // Shift-and-add GF(2^bw) multiply, used only for elaboration-time constants.
  function automatic int gf_mul(input int a, input int b, input int bw);
    int acc;
    int aa;
    acc = 0;
    aa  = a;
    for (int i = 0; i < C_MAX_BW; i++) begin
      if (i < bw && ((b >> i) & 1) == 1) acc = acc ^ aa;
      aa = aa << 1;
      if (((aa >> bw) & 1) == 1) aa = aa ^ prim_poly(bw);
    end
    return acc & ((1 << bw) - 1);
  endfunction

  // Generator g(x) = prod (x - alpha^i), i = 0..r-1; returns g[0..r-1]
  // packed LSB-first, the monic g[r] term is implicit.
  function automatic logic [C_MAX_R*C_MAX_BW-1:0] gen_poly(input int bw, input int r);
    int                            g [C_MAX_R+1];
    int                            root;
    logic [C_MAX_R*C_MAX_BW-1:0] res;
    for (int j = 0; j <= C_MAX_R; j++) g[j] = 0;
    g[0] = 1;
    root = 1;
    for (int i = 0; i < C_MAX_R; i++) begin
      if (i < r) begin
        for (int j = C_MAX_R; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root, bw);
        g[0] = gf_mul(g[0], root, bw);
        root = gf_mul(root, 2, bw);
      end
    end
    res = '0;
    for (int j = 0; j < C_MAX_R; j++) res[j*C_MAX_BW +: C_MAX_BW] = C_MAX_BW'(g[j]);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_const_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gf_const_mult                                                |
// | Description : Multiply a GF(2^SYM_BW) symbol by a fixed constant as a pure |
// |               XOR network (one column per input bit).                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gf_const_mult
  import rs_pkg::*;
#(
  parameter int SYM_BW = 8,
  parameter int COEF   = 1
) (
  input  logic [SYM_BW-1:0] a_i,
  output logic [SYM_BW-1:0] p_o
);

  logic [SYM_BW-1:0] w_cols [SYM_BW];

  // Column gi is COEF * alpha^gi, selected by input bit gi.
  for (genvar gi = 0; gi < SYM_BW; gi++) begin : g_col
    localparam int C_COL = gf_mul(COEF, 1 << gi, SYM_BW);
    assign w_cols[gi] = a_i[gi] ? C_COL[SYM_BW-1:0] : '0;
  end

  // XOR-reduce the selected columns into the product.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < SYM_BW; i++) p_o = p_o ^ w_cols[i];
  end

endmodule
`default_nettype wire

// File: rtl/rs_encoder_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs_encoder_core                                              |
// | Description : Systematic Reed-Solomon encoder. Message symbols pass        |
// |               through with one cycle latency, then R_NUM LFSR parity       |
// |               symbols are appended, highest coefficient first.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rs_encoder_core
  import rs_pkg::*;
#(
  parameter int SYM_BW = 8,
  parameter int N_NUM  = 255,
  parameter int R_NUM  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_val,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [SYM_BW-1:0] din,
  output logic              din_rdy,
  output logic              dout_val,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [SYM_BW-1:0] dout,
  output logic              frame_err
);

  localparam int C_K  = N_NUM - R_NUM;
  localparam int C_CW = $clog2(N_NUM + 1);
  localparam int C_PW = $clog2(R_NUM);
  localparam logic [C_MAX_R*C_MAX_BW-1:0] C_GEN = gen_poly(SYM_BW, R_NUM);

  state_e            state_q, state_d;
  logic [C_CW-1:0]   cnt_q, cnt_d;
  logic [C_PW-1:0]   pcnt_q, pcnt_d;
  logic [SYM_BW-1:0] lfsr_q [R_NUM];
  logic [SYM_BW-1:0] lfsr_d [R_NUM];
  logic [SYM_BW-1:0] w_prod [R_NUM];
  logic [SYM_BW-1:0] dout_q, dout_d;
  logic              dval_q, dval_d;
  logic              dsop_q, dsop_d;
  logic              deop_q, deop_d;
  logic              ferr_q, ferr_d;

  logic              w_accept, w_start, w_cont, w_take, w_close;
  logic              w_shift, w_flush;
  logic [C_CW-1:0]   w_cnt_next;
  logic [SYM_BW-1:0] w_fb;

  assign din_rdy    = (state_q != ST_PARITY);
  assign w_accept   = din_val & din_rdy;
  // A sop always (re)starts a frame; plain symbols only count inside DATA.
  assign w_start    = w_accept & din_sop;
  assign w_cont     = w_accept & ~din_sop & (state_q == ST_DATA);
  assign w_take     = w_start | w_cont;
  assign w_cnt_next = w_start ? C_CW'(1) : cnt_q + 1'b1;
  assign w_close    = w_take & (din_eop | (w_cnt_next == C_CW'(C_K)));
  // On a frame start the old register contents are ignored (cleared LFSR).
  assign w_fb       = din ^ (w_start ? '0 : lfsr_q[R_NUM-1]);

  for (genvar gi = 0; gi < R_NUM; gi++) begin : g_tap
    gf_const_mult #(
      .SYM_BW (SYM_BW),
      .COEF   (int'(C_GEN[gi*C_MAX_BW +: C_MAX_BW]))
    ) u_mult (
      .a_i (w_fb),
      .p_o (w_prod[gi])
    );
  end

  // Next state, counters and registered output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    w_shift = 1'b0;
    w_flush = 1'b0;
    dout_d  = '0;
    dval_d  = 1'b0;
    dsop_d  = 1'b0;
    deop_d  = 1'b0;
    ferr_d  = (w_start & (state_q == ST_DATA)) | (w_close & ~din_eop);
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (w_take) begin
          w_shift = 1'b1;
          cnt_d   = w_cnt_next;
          dval_d  = 1'b1;
          dsop_d  = din_sop;
          dout_d  = din;
          if (w_close) begin
            state_d = ST_PARITY;
            pcnt_d  = C_PW'(R_NUM - 1);
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_PARITY: begin
        w_flush = 1'b1;
        dval_d  = 1'b1;
        dout_d  = lfsr_q[R_NUM-1];
        pcnt_d  = pcnt_q - 1'b1;
        if (pcnt_q == '0) begin
          deop_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LFSR update: feedback shift on data, plain zero-fill shift on parity.
  always_comb begin
    for (int i = 0; i < R_NUM; i++) lfsr_d[i] = lfsr_q[i];
    if (w_shift) begin
      lfsr_d[0] = w_prod[0];
      for (int i = 1; i < R_NUM; i++) lfsr_d[i] = (w_start ? '0 : lfsr_q[i-1]) ^ w_prod[i];
    end else if (w_flush) begin
      lfsr_d[0] = '0;
      for (int i = 1; i < R_NUM; i++) lfsr_d[i] = lfsr_q[i-1];
    end
  end

  // State, counters and LFSR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      for (int i = 0; i < R_NUM; i++) lfsr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      for (int i = 0; i < R_NUM; i++) lfsr_q[i] <= lfsr_d[i];
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      dval_q <= 1'b0;
      dsop_q <= 1'b0;
      deop_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dval_q <= dval_d;
      dsop_q <= dsop_d;
      deop_q <= deop_d;
      ferr_q <= ferr_d;
    end
  end

  assign dout      = dout_q;
  assign dout_val  = dval_q;
  assign dout_sop  = dsop_q;
  assign dout_eop  = deop_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_encoder_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rs_encoder_core                                           |
// | Description : Scoreboard bench for rs_encoder_core (GF(256), R=32).        |
// |               Expected codewords come from polynomial long division.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rs_encoder_core;

  localparam int SYM_BW = 8;
  localparam int N_NUM  = 255;
  localparam int R_NUM  = 32;
  localparam int C_K    = N_NUM - R_NUM;

  typedef struct {
    logic [7:0] d;
    bit         s;
    bit         e;
    bit         f;
    int         acc;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_val, din_sop, din_eop;
  logic [7:0] din;
  logic       din_rdy, dout_val, dout_sop, dout_eop, frame_err;
  logic [7:0] dout;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         lowcnt = 0;
  int         last_eop_cyc = 0;
  bit         b2b_chk;
  bit         in_data;
  exp_t       sb [$];
  logic [7:0] msg [$];
  logic [7:0] gen [0:R_NUM];

  rs_encoder_core #(
    .SYM_BW (SYM_BW),
    .N_NUM  (N_NUM),
    .R_NUM  (R_NUM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_val   (din_val),
    .din_sop   (din_sop),
    .din_eop   (din_eop),
    .din       (din),
    .din_rdy   (din_rdy),
    .dout_val  (dout_val),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop),
    .dout      (dout),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge t, cyc == t.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Carry-less product then reduction by 0x11D.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h11D << (i - 8));
    return p[7:0];
  endfunction

  // Generator coefficients, highest degree first (gen[0] == 1).
  task automatic build_gen();
    logic [7:0] g [$];
    logic [7:0] n [$];
    logic [7:0] root;
    root = 8'h01;
    g = '{8'h01};
    for (int i = 0; i < R_NUM; i++) begin
      n = g;
      n.push_back(8'h00);
      for (int j = 1; j < n.size(); j++) n[j] = n[j] ^ gm(g[j-1], root);
      g = n;
      root = gm(root, 8'h02);
    end
    for (int j = 0; j <= R_NUM; j++) gen[j] = g[j];
  endtask

  task automatic push_parity(input int acc);
    logic [7:0] b [$];
    logic [7:0] c;
    int         m;
    b = msg;
    m = msg.size();
    repeat (R_NUM) b.push_back(8'h00);
    for (int i = 0; i < m; i++) begin
      c = b[i];
      if (c != 8'h00)
        for (int j = 1; j <= R_NUM; j++) b[i+j] = b[i+j] ^ gm(gen[j], c);
    end
    for (int j = 0; j < R_NUM; j++)
      sb.push_back('{b[m+j], 1'b0, (j == R_NUM - 1), 1'b0, acc, j + 1});
  endtask

  // Accept-level behaviour: what the codeword stream must look like.
  task automatic model_accept(input logic [7:0] d, input bit s, input bit e, input int acc);
    bit f;
    bit take;
    bit close;
    f = 1'b0;
    take = 1'b0;
    if (s) begin
      if (in_data) f = 1'b1;
      msg.delete();
      msg.push_back(d);
      in_data = 1'b1;
      take = 1'b1;
    end else if (in_data) begin
      msg.push_back(d);
      take = 1'b1;
    end
    if (take) begin
      close = e || (msg.size() == C_K);
      if (close && !e) f = 1'b1;
      sb.push_back('{d, s, 1'b0, f, acc, 0});
      if (close) begin
        push_parity(acc);
        in_data = 1'b0;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input bit s, input bit e);
    int waits;
    waits = 0;
    din_val = 1'b1;
    din     = d;
    din_sop = s;
    din_eop = e;
    @(negedge clk);
    while (!din_rdy && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!din_rdy) chk("rdy_timeout", 32'd0, 32'd1);
    else model_accept(d, s, e, cyc + 1);
    @(posedge clk);
    #1;
    din_val = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit do_eop, input bit zeros);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = zeros ? 8'h00 : 8'($urandom_range(0, 255));
      send(d, (i == 0), do_eop && (i == len - 1));
    end
  endtask

  task automatic idle(input int n);
    din_val = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_val"},  32'(dout_val), 32'd0);
    chk({tag, "_sop"},  32'(dout_sop), 32'd0);
    chk({tag, "_eop"},  32'(dout_eop), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_rdy"},  32'(din_rdy), 32'd1);
  endtask

  // Output monitor: pop and compare every valid output symbol.
  always @(negedge clk) begin
    exp_t r;
    if (!rst_n) begin
      lowcnt = 0;
    end else begin
      if (!din_rdy) lowcnt++;
      if (dout_val) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk("dout", 32'(dout), 32'(r.d));
          chk("dout_sop", 32'(dout_sop), 32'(r.s));
          chk("dout_eop", 32'(dout_eop), 32'(r.e));
          chk("frame_err", 32'(frame_err), 32'(r.f));
          chk("latency", 32'(cyc - r.acc), 32'(r.lat));
          if (r.s && b2b_chk) chk("b2b_gap", 32'(cyc - last_eop_cyc), 32'd1);
          if (r.e) begin
            chk("rdy_low_cycles", 32'(lowcnt), 32'(R_NUM));
            lowcnt = 0;
            last_eop_cyc = cyc;
          end
        end
      end else if (frame_err || dout_sop || dout_eop) begin
        chk("ctl_without_val", {29'd0, frame_err, dout_sop, dout_eop}, 32'd0);
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    din_val = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    din     = 8'h00;
    b2b_chk = 1'b0;
    in_data = 1'b0;
    build_gen();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Symbols without sop while idle are dropped.
    send(8'h55, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b1);
    idle(3);

    // All-zero shortened frame: all-zero parity.
    send_frame(3, 1'b1, 1'b1);
    idle(2);

    // Full-length random frame with eop on symbol K.
    send_frame(C_K, 1'b1, 1'b0);
    idle(2);

    // Back-to-back frames: sop must follow eop with no gap.
    send_frame(20, 1'b1, 1'b0);
    b2b_chk = 1'b1;
    send_frame(17, 1'b1, 1'b0);
    b2b_chk = 1'b0;
    idle(40);

    // sop inside DATA restarts the frame and flags an error.
    send_frame(10, 1'b0, 1'b0);
    send_frame(15, 1'b1, 1'b0);
    idle(2);

    // K symbols without eop: error pulse, parity follows anyway.
    send_frame(C_K, 1'b0, 1'b0);
    idle(2);

    // One-symbol frame (sop and eop together).
    send(8'h3C, 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of parity emission.
    send_frame(5, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    msg.delete();
    in_data = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Encoding after reset is unaffected by the aborted frame.
    send_frame(30, 1'b1, 1'b0);

    for (int w = 0; w < 2000 && sb.size() > 0; w++) @(posedge clk);
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
